ci_batch_initiator: RTL and testbench

- Master-side driver for the team's floating-point function-evaluation custom-instruction interface (clk_en/start/done, two 32-bit operands, 2-bit opcode n, 32-bit result).
- Accepts a batch command and issues CLEAR once.
- Streams operand pairs from an upstream valid/ready source, issuing one GO per pair.
- Issues READ at the end and presents the accumulated result with a one-cycle valid pulse. A per-instruction timeout guards against a hung responder.

---
 rtl/ci_batch_initiator.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ci_batch_initiator.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_batch_initiator.sv
// -----------------------------------------------------------------------------
// ci_batch_initiator
//
// Master-side driver for the floating-point function-evaluation custom
// instruction interface. A batch request issues CLEAR once, then one GO per
// operand pair pulled from an upstream valid/ready source, then READ. The READ
// result is presented on res_data with a one-cycle res_valid pulse. Every
// instruction is guarded by a timeout; on expiry the batch is abandoned and the
// sticky error flag is raised.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_start, cmd_count  batch request and its operand pair count
//   op_valid/op_ready     upstream operand pair handshake, op_a/op_b data
//   ci_clk_en, ci_start   custom-instruction enable and one-cycle issue strobe
//   ci_n, ci_dataa/datab  opcode and operands, held until ci_done is sampled
//   ci_done, ci_result    responder completion and result
//   busy                  batch in progress
//   res_valid, res_data   READ result pulse and held result
//   error                 sticky timeout flag
// -----------------------------------------------------------------------------
module ci_batch_initiator #(
   parameter int                 FLT_DATA_WIDTH = 32,
   parameter int                 N_WIDTH        = 2,
   parameter int                 CNT_WIDTH      = 8,
   parameter int                 TIMEOUT_CYCLES = 1024,
   parameter logic [N_WIDTH-1:0] CLEAR          = 2'd0,
   parameter logic [N_WIDTH-1:0] GO             = 2'd1,
   parameter logic [N_WIDTH-1:0] READ           = 2'd2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_start,
   input  logic [CNT_WIDTH-1:0]      cmd_count,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  logic [FLT_DATA_WIDTH-1:0] op_a,
   input  logic [FLT_DATA_WIDTH-1:0] op_b,
   output logic                      ci_clk_en,
   output logic                      ci_start,
   output logic [N_WIDTH-1:0]        ci_n,
   output logic [FLT_DATA_WIDTH-1:0] ci_dataa,
   output logic [FLT_DATA_WIDTH-1:0] ci_datab,
   input  logic                      ci_done,
   input  logic [FLT_DATA_WIDTH-1:0] ci_result,
   output logic                      busy,
   output logic                      res_valid,
   output logic [FLT_DATA_WIDTH-1:0] res_data,
   output logic                      error
);

   // Timeout counter holds the number of cycles elapsed since the issue strobe,
   // so it must be able to represent TIMEOUT_CYCLES itself.
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLR_ISSUE = 3'd1,
      ST_CLR_WAIT  = 3'd2,
      ST_FETCH     = 3'd3,
      ST_GO_ISSUE  = 3'd4,
      ST_GO_WAIT   = 3'd5,
      ST_RD_ISSUE  = 3'd6,
      ST_RD_WAIT   = 3'd7
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [CNT_WIDTH-1:0]        r_remaining;
   logic [CNT_WIDTH-1:0]        w_remaining_nxt;
   logic [TMO_W-1:0]            r_tmo;
   logic [TMO_W-1:0]            w_tmo_nxt;

   logic                        r_busy;
   logic                        r_op_ready;
   logic                        r_ci_start;
   logic [N_WIDTH-1:0]          r_ci_n;
   logic [FLT_DATA_WIDTH-1:0]   r_ci_dataa;
   logic [FLT_DATA_WIDTH-1:0]   r_ci_datab;
   logic                        r_res_valid;
   logic [FLT_DATA_WIDTH-1:0]   r_res_data;
   logic                        r_error;

   logic                        w_busy_nxt;
   logic                        w_op_ready_nxt;
   logic                        w_ci_start_nxt;
   logic [N_WIDTH-1:0]          w_ci_n_nxt;
   logic [FLT_DATA_WIDTH-1:0]   w_ci_dataa_nxt;
   logic [FLT_DATA_WIDTH-1:0]   w_ci_datab_nxt;
   logic                        w_res_valid_nxt;
   logic [FLT_DATA_WIDTH-1:0]   w_res_data_nxt;
   logic                        w_error_nxt;

   logic                        w_rem_zero;
   logic                        w_in_wait;
   logic                        w_expire;

   assign w_rem_zero = (r_remaining == {CNT_WIDTH{1'b0}});
   assign w_in_wait  = (r_state == ST_CLR_WAIT) || (r_state == ST_GO_WAIT) ||
                       (r_state == ST_RD_WAIT);
   // A done on the expiry cycle wins, so expiry requires ci_done low.
   assign w_expire   = w_in_wait && !ci_done && (r_tmo == TMO_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; ci_done only matters in the WAIT states.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (cmd_start) begin
               w_state_nxt = ST_CLR_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CLR_ISSUE: w_state_nxt = ST_CLR_WAIT;
         ST_CLR_WAIT, ST_GO_WAIT: begin
            if (ci_done) begin
               if (w_rem_zero) begin
                  w_state_nxt = ST_RD_ISSUE;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_FETCH: begin
            if (op_valid) begin
               w_state_nxt = ST_GO_ISSUE;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_GO_ISSUE: w_state_nxt = ST_GO_WAIT;
         ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (ci_done || w_expire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RD_WAIT;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output/datapath next values; flags derive from the next state so every
   // output comes straight from a flop.
   always_comb begin
      w_busy_nxt      = (w_state_nxt != ST_IDLE);
      w_op_ready_nxt  = (w_state_nxt == ST_FETCH);
      w_ci_start_nxt  = (w_state_nxt == ST_CLR_ISSUE) || (w_state_nxt == ST_GO_ISSUE) ||
                        (w_state_nxt == ST_RD_ISSUE);
      w_ci_n_nxt      = r_ci_n;
      w_ci_dataa_nxt  = r_ci_dataa;
      w_ci_datab_nxt  = r_ci_datab;
      w_remaining_nxt = r_remaining;
      w_tmo_nxt       = {TMO_W{1'b0}};
      w_res_valid_nxt = 1'b0;
      w_res_data_nxt  = r_res_data;
      w_error_nxt     = r_error;
      case (r_state)
         ST_IDLE: begin
            if (cmd_start) begin
               w_ci_n_nxt      = CLEAR;
               w_ci_dataa_nxt  = {FLT_DATA_WIDTH{1'b0}};
               w_ci_datab_nxt  = {FLT_DATA_WIDTH{1'b0}};
               w_remaining_nxt = cmd_count;
               w_error_nxt     = 1'b0;
            end else begin
               w_error_nxt     = r_error;
            end
         end
         ST_CLR_ISSUE, ST_GO_ISSUE, ST_RD_ISSUE: begin
            // Counting starts at the strobe cycle itself.
            w_tmo_nxt = TMO_W'(1);
         end
         ST_CLR_WAIT, ST_GO_WAIT: begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
            if (ci_done && w_rem_zero) begin
               w_ci_n_nxt     = READ;
               w_ci_dataa_nxt = {FLT_DATA_WIDTH{1'b0}};
               w_ci_datab_nxt = {FLT_DATA_WIDTH{1'b0}};
            end else begin
               w_ci_n_nxt     = r_ci_n;
            end
            if (w_expire) begin
               w_error_nxt = 1'b1;
            end else begin
               w_error_nxt = r_error;
            end
         end
         ST_FETCH: begin
            if (op_valid) begin
               // FETCH is only entered with remaining nonzero, so no underflow.
               w_ci_n_nxt      = GO;
               w_ci_dataa_nxt  = op_a;
               w_ci_datab_nxt  = op_b;
               w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
            end else begin
               w_remaining_nxt = r_remaining;
            end
         end
         ST_RD_WAIT: begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
            if (ci_done) begin
               w_res_valid_nxt = 1'b1;
               w_res_data_nxt  = ci_result;
            end else if (w_expire) begin
               w_error_nxt     = 1'b1;
            end else begin
               w_error_nxt     = r_error;
            end
         end
         default: begin
            w_tmo_nxt = {TMO_W{1'b0}};
         end
      endcase
   end

   // Output, counter and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_remaining <= {CNT_WIDTH{1'b0}};
         r_tmo       <= {TMO_W{1'b0}};
         r_busy      <= 1'b0;
         r_op_ready  <= 1'b0;
         r_ci_start  <= 1'b0;
         r_ci_n      <= {N_WIDTH{1'b0}};
         r_ci_dataa  <= {FLT_DATA_WIDTH{1'b0}};
         r_ci_datab  <= {FLT_DATA_WIDTH{1'b0}};
         r_res_valid <= 1'b0;
         r_res_data  <= {FLT_DATA_WIDTH{1'b0}};
         r_error     <= 1'b0;
      end else begin
         r_remaining <= w_remaining_nxt;
         r_tmo       <= w_tmo_nxt;
         r_busy      <= w_busy_nxt;
         r_op_ready  <= w_op_ready_nxt;
         r_ci_start  <= w_ci_start_nxt;
         r_ci_n      <= w_ci_n_nxt;
         r_ci_dataa  <= w_ci_dataa_nxt;
         r_ci_datab  <= w_ci_datab_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_data  <= w_res_data_nxt;
         r_error     <= w_error_nxt;
      end
   end

   assign busy      = r_busy;
   assign ci_clk_en = r_busy;
   assign op_ready  = r_op_ready;
   assign ci_start  = r_ci_start;
   assign ci_n      = r_ci_n;
   assign ci_dataa  = r_ci_dataa;
   assign ci_datab  = r_ci_datab;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign error     = r_error;

endmodule

// File: tb/tb_ci_batch_initiator.sv
// -----------------------------------------------------------------------------
// Testbench for ci_batch_initiator: a stub responder with programmable done
// latency, an upstream operand source with per-pair gaps counted in FETCH
// cycles, and a batch-level model (expected instruction list, result and
// latency computed from the pair list and responder latency).
// -----------------------------------------------------------------------------
module tb_ci_batch_initiator;

   localparam int         TMO        = 16;
   localparam logic [1:0] OPC_CLEAR  = 2'd0;
   localparam logic [1:0] OPC_GO     = 2'd1;
   localparam logic [1:0] OPC_READ   = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_start;
   logic [7:0]  cmd_count;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ci_clk_en;
   logic        ci_start;
   logic [1:0]  ci_n;
   logic [31:0] ci_dataa;
   logic [31:0] ci_datab;
   logic        ci_done;
   logic [31:0] ci_result;
   logic        busy;
   logic        res_valid;
   logic [31:0] res_data;
   logic        error;

   ci_batch_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_count(cmd_count),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
      .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_done(ci_done),
      .ci_result(ci_result), .busy(busy), .res_valid(res_valid),
      .res_data(res_data), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] a; logic [31:0] b; int gap; } pair_t;
   typedef struct { logic [1:0] n; logic [31:0] a; logic [31:0] b; } instr_t;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          mon_bad = 0;
   int          rv_count = 0;
   int          fetch_cycles = 0;
   int          resp_d = 1;
   bit          mute_go = 1'b0;
   bit          resp_off = 1'b0;
   bit          stray_fetch = 1'b0;
   bit          stray_now = 1'b0;
   int          src_gap = 0;
   logic [31:0] rd_val = 32'h0;
   pair_t       src_q[$];
   pair_t       plan_q[$];
   instr_t      ilog[$];

   // Stub responder plus protocol monitor.
   initial begin
      bit     pending;
      bit     prev_start;
      int     cnt;
      instr_t cur;
      pending = 1'b0; prev_start = 1'b0; cnt = 0;
      cur.n = 2'd0; cur.a = 32'h0; cur.b = 32'h0;
      ci_done = 1'b0; ci_result = 32'h0;
      forever begin
         @(posedge clk); #1;
         ci_done = 1'b0;
         if (resp_off) pending = 1'b0;
         if (res_valid === 1'b1) rv_count++;
         if (ci_clk_en !== busy) mon_bad++;
         if (ci_start === 1'b1 && prev_start) mon_bad++;
         if (ci_start === 1'b1 && op_ready === 1'b1) mon_bad++;
         if (pending) begin
            if (ci_n !== cur.n || ci_dataa !== cur.a || ci_datab !== cur.b) mon_bad++;
            if (op_ready !== 1'b0) mon_bad++;
            cnt--;
            if (cnt == 0) begin
               ci_done = 1'b1;
               ci_result = (cur.n == OPC_READ) ? rd_val : $urandom;
               pending = 1'b0;
            end
         end
         if (stray_now) begin
            ci_done = 1'b1; ci_result = $urandom; stray_now = 1'b0;
         end
         if (stray_fetch && op_ready === 1'b1 && !pending) begin
            ci_done = 1'b1; ci_result = $urandom; stray_fetch = 1'b0;
         end
         if (ci_start === 1'b1 && !resp_off) begin
            cur.n = ci_n; cur.a = ci_dataa; cur.b = ci_datab;
            ilog.push_back(cur);
            if (!(mute_go && ci_n == OPC_GO)) begin
               pending = 1'b1; cnt = resp_d;
            end
         end
         prev_start = (ci_start === 1'b1);
      end
   end

   // Upstream operand source; a pair's gap is counted in cycles with op_ready high.
   initial begin
      bit    hs;
      pair_t tmp;
      hs = 1'b0;
      op_valid = 1'b0; op_a = 32'h0; op_b = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (hs && src_q.size() > 0) begin
            tmp = src_q.pop_front();
            if (!(ci_start === 1'b1 && ci_n === OPC_GO)) mon_bad++;
            if (src_q.size() > 0) src_gap = src_q[0].gap;
         end
         if (op_ready === 1'b1) fetch_cycles++;
         if (src_q.size() == 0) begin
            op_valid = 1'b0;
         end else if (src_gap > 0) begin
            op_valid = 1'b0;
            if (op_ready === 1'b1) src_gap--;
         end else begin
            op_valid = 1'b1; op_a = src_q[0].a; op_b = src_q[0].b;
         end
         hs = op_valid && (op_ready === 1'b1);
      end
   end

   task automatic add_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
      pair_t p;
      p.a = a; p.b = b; p.gap = gap;
      plan_q.push_back(p);
   endtask

   // Runs one batch built from plan_q and checks it against the batch model.
   task automatic run_batch(input string name, input int d, input logic [31:0] rv, input bit poke);
      pair_t  plan[$];
      instr_t e;
      int     n, total_gap, exp_lat, lat, rv0, fc0, bad_idx;
      bit     got, busy_at_res;
      logic [31:0] data_at_res;
      plan = plan_q;
      n = plan.size();
      total_gap = 0;
      foreach (plan[i]) total_gap += plan[i].gap;
      exp_lat = (n + 2) * (1 + d) + n + total_gap;
      resp_d = d; rd_val = rv; ilog.delete(); mon_bad = 0;
      rv0 = rv_count; fc0 = fetch_cycles;
      src_q = plan; src_gap = (n > 0) ? plan[0].gap : 0;
      cmd_count = 8'(n); cmd_start = 1'b1;
      got = 1'b0; lat = -1; busy_at_res = 1'b1; data_at_res = 32'h0;
      for (int idx = 0; idx < exp_lat + 300 && !got; idx++) begin
         @(posedge clk); #1;
         if (idx == 0) begin
            cmd_start = 1'b0;
            total_cnt++;
            if (busy !== 1'b1 || error !== 1'b0)
               $display("FAIL %s start: busy=%b error=%b expected busy=1 error=0", name, busy, error);
            else pass_cnt++;
         end
         if (poke && idx == 3) begin cmd_start = 1'b1; cmd_count = 8'd7; end
         if (poke && idx == 4) cmd_start = 1'b0;
         if (res_valid === 1'b1) begin
            got = 1'b1; lat = idx; busy_at_res = busy; data_at_res = res_data;
         end
      end
      total_cnt++;
      if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (busy_at_res !== 1'b0) $display("FAIL %s busy_at_res: got %b expected 0", name, busy_at_res);
      else pass_cnt++;
      total_cnt++;
      if (data_at_res !== rv) $display("FAIL %s res_data: got %h expected %h", name, data_at_res, rv);
      else pass_cnt++;
      total_cnt++;
      if (ilog.size() != n + 2) $display("FAIL %s instr_count: got %0d expected %0d", name, ilog.size(), n + 2);
      else pass_cnt++;
      bad_idx = -1;
      for (int i = 0; i < n + 2 && i < ilog.size(); i++) begin
         if (i == 0) begin e.n = OPC_CLEAR; e.a = 32'h0; e.b = 32'h0; end
         else if (i == n + 1) begin e.n = OPC_READ; e.a = 32'h0; e.b = 32'h0; end
         else begin e.n = OPC_GO; e.a = plan[i-1].a; e.b = plan[i-1].b; end
         if (bad_idx < 0 && (ilog[i].n !== e.n || ilog[i].a !== e.a || ilog[i].b !== e.b)) bad_idx = i;
      end
      total_cnt++;
      if (bad_idx >= 0)
         $display("FAIL %s instr_order: index %0d got n=%0d a=%h b=%h expected n=%0d a=%h b=%h", name, bad_idx,
                  ilog[bad_idx].n, ilog[bad_idx].a, ilog[bad_idx].b,
                  (bad_idx == 0) ? OPC_CLEAR : ((bad_idx == n + 1) ? OPC_READ : OPC_GO),
                  (bad_idx == 0 || bad_idx == n + 1) ? 32'h0 : plan[bad_idx-1].a,
                  (bad_idx == 0 || bad_idx == n + 1) ? 32'h0 : plan[bad_idx-1].b);
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (rv_count - rv0 != 1 || busy !== 1'b0 || error !== 1'b0 || res_data !== rv)
         $display("FAIL %s post: res_valid pulses=%0d busy=%b error=%b res_data=%h expected 1,0,0,%h",
                  name, rv_count - rv0, busy, error, res_data, rv);
      else pass_cnt++;
      total_cnt++;
      if (fetch_cycles - fc0 != n + total_gap)
         $display("FAIL %s op_ready_cycles: got %0d expected %0d", name, fetch_cycles - fc0, n + total_gap);
      else pass_cnt++;
      total_cnt++;
      if (mon_bad != 0) $display("FAIL %s protocol: violations=%0d expected 0", name, mon_bad);
      else pass_cnt++;
      src_q.delete(); src_gap = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      total_cnt++;
      if ({busy, op_ready, ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab, res_valid, res_data, error} !== 104'h0)
         $display("FAIL reset_outputs: busy=%b op_ready=%b ci_start=%b ci_n=%0d res_valid=%b error=%b expected all 0",
                  busy, op_ready, ci_start, ci_n, res_valid, error);
      else pass_cnt++;
      repeat (5) @(posedge clk);
      #1;
      total_cnt++;
      if (busy !== 1'b0 || op_ready !== 1'b0 || ci_start !== 1'b0)
         $display("FAIL reset_idle: busy=%b op_ready=%b ci_start=%b expected 0", busy, op_ready, ci_start);
      else pass_cnt++;
   endtask

   task automatic test_directed();
      plan_q.delete();
      add_pair(32'h3F800000, 32'h3F000000, 0);
      add_pair(32'h40000000, 32'h3F800000, 0);
      run_batch("directed", 3, 32'h40490FDB, 1'b0);
   endtask

   task automatic test_zero_count();
      plan_q.delete();
      run_batch("zero_count", 2, 32'h12345678, 1'b0);
   endtask

   task automatic test_fetch_gap();
      plan_q.delete();
      add_pair(32'hC0A00000, 32'h41200000, 10);
      add_pair(32'h7F800000, 32'h00000001, 0);
      run_batch("fetch_gap", 1, 32'hBF800000, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      plan_q.delete();
      add_pair(32'h3E99999A, 32'h3F4CCCCD, 3);
      add_pair(32'h42280000, 32'hC2280000, 0);
      add_pair(32'hFFFFFFFF, 32'h80000000, 1);
      stray_fetch = 1'b1;
      run_batch("ignored_inputs", 2, 32'h3F7FFFFF, 1'b1);
      stray_fetch = 1'b0;
   endtask

   task automatic test_max_count();
      plan_q.delete();
      for (int i = 0; i < 255; i++) add_pair($urandom, $urandom, 0);
      run_batch("max_count", 1, 32'hDEADBEEF, 1'b0);
   endtask

   task automatic test_done_at_expiry();
      plan_q.delete();
      add_pair(32'h40400000, 32'h40800000, 0);
      run_batch("done_at_expiry", TMO - 1, 32'h5A5AA5A5, 1'b0);
   endtask

   task automatic test_timeout();
      int g, e, rv0;
      plan_q.delete();
      add_pair(32'h3F800000, 32'h40000000, 0);
      mute_go = 1'b1; resp_d = 2; ilog.delete();
      rv0 = rv_count;
      src_q = plan_q; src_gap = 0;
      cmd_count = 8'd1; cmd_start = 1'b1;
      g = -1; e = -1;
      for (int idx = 0; idx < 200 && e < 0; idx++) begin
         @(posedge clk); #1;
         if (idx == 0) cmd_start = 1'b0;
         if (g < 0 && ci_start === 1'b1 && ci_n === OPC_GO) g = idx;
         if (error === 1'b1) e = idx;
      end
      total_cnt++;
      if (g < 0 || e - g != TMO) $display("FAIL timeout_delay: got %0d cycles expected %0d", e - g, TMO);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || ci_clk_en !== 1'b0 || op_ready !== 1'b0)
         $display("FAIL timeout_idle: busy=%b ci_clk_en=%b op_ready=%b expected 0", busy, ci_clk_en, op_ready);
      else pass_cnt++;
      repeat (5) @(posedge clk);
      #1;
      total_cnt++;
      if (error !== 1'b1 || rv_count != rv0 || busy !== 1'b0)
         $display("FAIL timeout_sticky: error=%b res_valid pulses=%0d busy=%b expected 1,0,0", error, rv_count - rv0, busy);
      else pass_cnt++;
      mute_go = 1'b0; src_q.delete(); src_gap = 0;
      plan_q.delete();
      add_pair(32'h11111111, 32'h22222222, 0);
      run_batch("after_timeout", 2, 32'h33333333, 1'b0);
   endtask

   task automatic test_random();
      int n, d;
      for (int b = 0; b < 8; b++) begin
         plan_q.delete();
         n = $urandom_range(0, 6);
         d = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) add_pair($urandom, $urandom, $urandom_range(0, 3));
         run_batch($sformatf("random%0d", b), d, $urandom, 1'b0);
      end
   endtask

   task automatic test_reset_mid_batch();
      int rv0, starts;
      bit seen;
      plan_q.delete();
      add_pair(32'hAAAA5555, 32'h5555AAAA, 0);
      add_pair(32'h01020304, 32'h05060708, 0);
      add_pair(32'h0A0B0C0D, 32'h0E0F1011, 0);
      resp_d = 6; ilog.delete(); rv0 = rv_count;
      src_q = plan_q; src_gap = 0;
      cmd_count = 8'd3; cmd_start = 1'b1;
      seen = 1'b0;
      for (int idx = 0; idx < 100 && !seen; idx++) begin
         @(posedge clk); #1;
         cmd_start = 1'b0;
         if (ci_start === 1'b1 && ci_n === OPC_GO) seen = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (!seen || busy !== 1'b1) $display("FAIL midreset_reach_go_wait: seen=%b busy=%b expected 1,1", seen, busy);
      else pass_cnt++;
      resp_off = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      src_q.delete(); src_gap = 0;
      total_cnt++;
      if ({busy, op_ready, ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab, res_valid, res_data, error} !== 104'h0)
         $display("FAIL midreset_outputs: busy=%b op_ready=%b ci_n=%0d ci_dataa=%h res_data=%h expected all 0",
                  busy, op_ready, ci_n, ci_dataa, res_data);
      else pass_cnt++;
      starts = 0;
      for (int idx = 0; idx < 20; idx++) begin
         if (idx == 4) stray_now = 1'b1;
         @(posedge clk); #1;
         if (ci_start === 1'b1 || busy !== 1'b0) starts++;
      end
      total_cnt++;
      if (starts != 0 || rv_count != rv0)
         $display("FAIL midreset_quiet: active cycles=%0d res_valid pulses=%0d expected 0,0", starts, rv_count - rv0);
      else pass_cnt++;
      resp_off = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_start = 1'b0; cmd_count = 8'd0;
      test_reset();
      test_directed();
      test_zero_count();
      test_fetch_gap();
      test_ignored_inputs();
      test_max_count();
      test_done_at_expiry();
      test_timeout();
      test_random();
      test_reset_mid_batch();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
